// File: rtl/move_sequencer_pkg.sv
// Shared types and helpers for the move-buffer sequencer.
package move_sequencer_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Next ring slot; wraps at size-1 so non-power-of-two rings work.
  function automatic int unsigned next_slot(input int unsigned idx,
                                            input int unsigned size);
    return (idx >= size - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/move_sequencer_tick_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous tick.
// edge_o is high for one cycle when the synchronised pair reads 0 -> 1.
module move_sequencer_tick_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  output logic edge_o
);

  // [0],[1] are the synchroniser, [2] holds the previous synchronised value
  logic [2:0] sync_q;

  // Shift the raw tick through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], tick_i};
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/move_sequencer.sv
// Move-buffer sequencer: walks a ring of host-filled move slots, times each
// move in DDA ticks and hands completion back through per-slot toggles.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned buffer_size        = 4,
  parameter int unsigned buffer_bits        = 2,
  parameter int unsigned move_duration_bits = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dda_tick,
  input  logic [move_duration_bits-1:0] move_duration,
  input  logic [buffer_size-1:0]        stepready,
  input  logic                          hold,
  input  logic                          abort,
  output logic [buffer_bits-1:0]        moveind,
  output logic [buffer_size-1:0]        stepfinished,
  output logic                          loading_move,
  output logic                          executing_move,
  output logic                          move_done,
  output logic                          move_done_pulse,
  output logic                          underrun,
  output logic                          abort_done,
  output logic                          buffer_dtr,
  output logic                          buffer_empty
);

  seq_state_e                    state_q, state_d;
  logic [buffer_bits-1:0]        moveind_q, moveind_d, moveind_nxt;
  logic [move_duration_bits-1:0] cnt_q, cnt_d;
  logic [buffer_size-1:0]        sf_q, sf_d, pending, slot_oh;
  logic                          md_q, md_d;
  logic                          mdp_q, mdp_d;
  logic                          und_q, und_d;
  logic                          abd_q, abd_d;
  logic                          tick_edge;

  move_sequencer_tick_edge_sync u_tick_sync (
    .clk    (clk),
    .reset  (reset),
    .tick_i (dda_tick),
    .edge_o (tick_edge)
  );

  // A slot is pending while the host toggle and our toggle disagree
  assign pending     = stepready ^ sf_q;
  assign moveind_nxt = buffer_bits'(next_slot(32'(moveind_q), buffer_size));
  assign slot_oh     = {{(buffer_size-1){1'b0}}, 1'b1} << moveind_q;

  // Next-state: abort overrides everything, completion beats a tick edge
  always_comb begin
    state_d   = state_q;
    moveind_d = moveind_q;
    cnt_d     = cnt_q;
    sf_d      = sf_q;
    md_d      = md_q;
    mdp_d     = 1'b0;
    und_d     = 1'b0;
    abd_d     = 1'b0;
    if (abort) begin
      sf_d      = stepready;
      moveind_d = '0;
      cnt_d     = '0;
      state_d   = ST_LOAD;
      abd_d     = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (pending[moveind_q]) begin
            cnt_d   = move_duration;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            sf_d      = sf_q ^ slot_oh;
            md_d      = ~md_q;
            mdp_d     = 1'b1;
            und_d     = ~pending[moveind_nxt];
            moveind_d = moveind_nxt;
            state_d   = ST_LOAD;
          end else if (tick_edge && !hold) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      moveind_q <= '0;
      cnt_q     <= '0;
      sf_q      <= '0;
      md_q      <= 1'b0;
      mdp_q     <= 1'b0;
      und_q     <= 1'b0;
      abd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      moveind_q <= moveind_d;
      cnt_q     <= cnt_d;
      sf_q      <= sf_d;
      md_q      <= md_d;
      mdp_q     <= mdp_d;
      und_q     <= und_d;
      abd_q     <= abd_d;
    end
  end

  assign moveind         = moveind_q;
  assign stepfinished    = sf_q;
  assign loading_move    = (state_q == ST_LOAD) && pending[moveind_q];
  assign executing_move  = (state_q == ST_RUN);
  assign move_done       = md_q;
  assign move_done_pulse = mdp_q;
  assign underrun        = und_q;
  assign abort_done      = abd_q;
  assign buffer_dtr      = ~(&pending);
  assign buffer_empty    = ~(|pending);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: a 4-slot and a 3-slot instance.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dda_tick, hold, abort;
  logic [31:0] move_duration;
  logic [3:0]  stepready, stepfinished;
  logic [1:0]  moveind;
  logic        loading_move, executing_move, move_done, move_done_pulse;
  logic        underrun, abort_done, buffer_dtr, buffer_empty;

  logic        tick3;
  logic [31:0] dur3;
  logic [2:0]  sr3, sf3;
  logic [1:0]  mi3;
  logic        ld3, ex3, md3, mdp3, und3, abd3, dtr3, emp3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  move_sequencer #(.buffer_size(4), .buffer_bits(2), .move_duration_bits(32)) u_dut (
    .clk(clk), .reset(reset), .dda_tick(dda_tick), .move_duration(move_duration),
    .stepready(stepready), .hold(hold), .abort(abort), .moveind(moveind),
    .stepfinished(stepfinished), .loading_move(loading_move),
    .executing_move(executing_move), .move_done(move_done),
    .move_done_pulse(move_done_pulse), .underrun(underrun),
    .abort_done(abort_done), .buffer_dtr(buffer_dtr), .buffer_empty(buffer_empty)
  );

  move_sequencer #(.buffer_size(3), .buffer_bits(2), .move_duration_bits(32)) u_dut3 (
    .clk(clk), .reset(reset), .dda_tick(tick3), .move_duration(dur3),
    .stepready(sr3), .hold(1'b0), .abort(1'b0), .moveind(mi3),
    .stepfinished(sf3), .loading_move(ld3), .executing_move(ex3),
    .move_done(md3), .move_done_pulse(mdp3), .underrun(und3),
    .abort_done(abd3), .buffer_dtr(dtr3), .buffer_empty(emp3)
  );

  // Slot durations 1,2,1 for the 3-slot ring, selected by the loading slot
  always_comb begin
    dur3 = 32'd1;
    if (mi3 == 2'd1) dur3 = 32'd2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stepready = '0; sr3 = '0; hold = 1'b0; abort = 1'b0;
    dda_tick = 1'b0; tick3 = 1'b0; move_duration = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // One tick: rising edge then 3 low cycles; the decrement lands on the
  // 3rd clock edge of the window, so h covers the whole detection window.
  task automatic tick_win(input logic h);
    hold = h;
    dda_tick = 1'b1; cyc();
    dda_tick = 1'b0; cyc(); cyc(); cyc();
    hold = 1'b0;
  endtask

  logic [1:0] exp_mi [3] = '{2'd1, 2'd2, 2'd0};
  logic       exp_md [3] = '{1'b1, 1'b0, 1'b1};
  logic       exp_un [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int ndone;

    // ---- reset state
    do_reset();
    cyc();
    chk("rst_moveind", moveind, 0);
    chk("rst_sf", stepfinished, 0);
    chk("rst_md", move_done, 0);
    chk("rst_pulses", {move_done_pulse, underrun, abort_done}, 0);
    chk("rst_exec", executing_move, 0);
    chk("rst_empty_dtr", {buffer_empty, buffer_dtr}, 2'b11);

    // ---- single move, duration 3, three ticks
    move_duration = 32'd3; stepready = 4'b0001;
    #1;
    chk("t1_loading", loading_move, 1);
    cyc();
    chk("t1_ld_ex", {loading_move, executing_move}, 2'b01);
    tick_win(1'b0); tick_win(1'b0);
    dda_tick = 1'b1; cyc();
    dda_tick = 1'b0; cyc(); cyc();
    chk("t1_still_run", {executing_move, move_done}, 2'b10);
    cyc();
    chk("t1_done", {executing_move, move_done, move_done_pulse, underrun}, 4'b0111);
    chk("t1_moveind", moveind, 1);
    chk("t1_sf", stepfinished, 4'b0001);
    cyc();
    chk("t1_pulse_off", {move_done_pulse, underrun}, 2'b00);

    // ---- duration 0 completes without ticks
    do_reset();
    move_duration = 32'd0; stepready = 4'b0001;
    cyc();
    chk("t3_cyc1", {executing_move, move_done_pulse}, 2'b10);
    cyc();
    chk("t3_cyc2", {move_done_pulse, move_done}, 2'b11);

    // ---- duration 5 with ticks 2,3 held
    do_reset();
    move_duration = 32'd5; stepready = 4'b0001;
    cyc();
    tick_win(1'b0); tick_win(1'b1); tick_win(1'b1); tick_win(1'b0); tick_win(1'b0);
    chk("t4_after5", {executing_move, move_done}, 2'b10);
    tick_win(1'b0);
    chk("t4_after6", {executing_move, move_done}, 2'b10);
    tick_win(1'b0);
    chk("t4_after7", {executing_move, move_done, move_done_pulse}, 3'b011);

    // ---- all pending, dtr, then abort mid-run of slot 1
    do_reset();
    move_duration = 32'd0; stepready = 4'b1111;
    #1;
    chk("t6_dtr_full", {buffer_dtr, buffer_empty}, 2'b00);
    cyc(); cyc();
    chk("t6_first_done", {move_done_pulse, underrun}, 2'b10);
    chk("t6_dtr_after", buffer_dtr, 1);
    move_duration = 32'd10;
    cyc();
    tick_win(1'b0);
    chk("t5_running", {executing_move, moveind}, {1'b1, 2'd1});
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_abort_done", {abort_done, move_done_pulse, executing_move}, 3'b100);
    chk("t5_sf", stepfinished, 4'b1111);
    chk("t5_moveind", moveind, 0);
    chk("t5_empty_md", {buffer_empty, move_done}, 2'b11);
    cyc();
    chk("t5_abort_off", {abort_done, loading_move}, 2'b00);

    // ---- 3-slot ring, durations 1,2,1, free-running tick
    sr3 = 3'b111;
    ndone = 0;
    for (int c = 0; c < 300 && ndone < 3; c++) begin
      tick3 = ~tick3;
      cyc();
      if (mdp3) begin
        chk("t2_moveind", mi3, exp_mi[ndone]);
        chk("t2_md", md3, exp_md[ndone]);
        chk("t2_underrun", und3, exp_un[ndone]);
        ndone++;
      end
    end
    chk("t2_completions", ndone, 3);
    chk("t2_empty", emp3, 1);
    chk("t2_sf", sf3, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Parametrised move-buffer sequencer between the host-facing move buffer (SPI/register file) and the per-axis DDA step generators. Walks an N-slot ring of move slots using a toggle-latch handshake, times each move in DDA ticks, and reports completion and flow control. Adds non-power-of-two ring depth, hold/pause, abort/flush and underrun reporting.

## Interface
- buffer_size, 4: number of move slots; any value ≥ 2, non-power-of-two allowed
- buffer_bits, 2: slot index width; must satisfy 2**buffer_bits ≥ buffer_size
- move_duration_bits, 32: width of the move duration in DDA ticks
- Reset is synchronous and active-high.
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous active-high reset
- dda_tick  in  1  DDA tick; may be asynchronous; rising edges counted
- move_duration  in  move_duration_bits  duration of slot moveind; sampled only in LOAD
- stepready  in  buffer_size  per-slot host toggle; slot i pending when stepready[i] != stepfinished[i]
- hold  in  1  freezes the downcount while high
- abort  in  1  single-cycle flush request
- moveind  out  buffer_bits  slot currently loading or executing
- stepfinished  out  buffer_size  per-slot completion toggles
- loading_move  out  1  high in LOAD while slot moveind is pending
- executing_move  out  1  high in RUN
- move_done  out  1  toggles once per completed move
- move_done_pulse  out  1  one-cycle pulse per completed move
- underrun  out  1  one-cycle pulse: move completed and next slot not pending
- abort_done  out  1  one-cycle pulse after a flush
- buffer_dtr  out  1  high unless every slot is pending
- buffer_empty  out  1  high when no slot is pending

## Operation
- States: LOAD, RUN. Reset state LOAD.
- LOAD: if slot moveind is pending, capture tickdowncount ← move_duration and enter RUN next cycle; otherwise stay.
- RUN: a detected tick edge with hold low decrements tickdowncount. When tickdowncount == 0: toggle stepfinished[moveind], toggle move_done, pulse move_done_pulse, advance moveind (buffer_size−1 wraps to 0), return to LOAD.
- Completion check has priority over a simultaneous tick edge; the counter never underflows.
- move_duration == 0: move completes on the first RUN cycle.
- underrun pulses with move_done_pulse when the next slot (post-wrap) is not pending in that same cycle.
- abort (any state, priority over everything): stepfinished ← stepready, moveind ← 0, state ← LOAD, pulse abort_done; move_done and move_done_pulse unchanged/low. The host must rewind its write pointer to 0.
- hold does not block LOAD or completion of an already-zero count.
- buffer_dtr = !(all pending); buffer_empty = !(any pending); both combinational from stepready/stepfinished.
- Reset values: moveind 0, stepfinished 0, move_done 0, all pulses 0, state LOAD, tickdowncount 0, tick-sync flops 0.

## Timing
- dda_tick passes through two synchroniser flops; an edge is detected when the sync pair reads 01. A rising dda_tick before edge k decrements the count at edge k+2.
- LOAD→RUN: 1 cycle. Minimum move (duration 0): LOAD 1 cycle + RUN 1 cycle.
- Duration D ≥ 1: completion is the cycle after the D-th counted edge.
- Back-to-back moves: one LOAD cycle between consecutive RUN periods.
- The host may toggle stepready for any non-pending slot at any cycle; a toggle on the active slot while RUN is a protocol violation (undefined).
- Reset mid-move discards the move; the slot toggles are cleared to 0, so the host must also clear stepready.

## Structure
- Shared package: state enum (LOAD, RUN) and a function returning the next wrapped index for a given buffer_size.
- One sub-module is natural: tick_edge_sync (2-flop synchroniser plus rising-edge detector), reusable by the step generators.

## Test plan
- Reset; stepready=0001, duration=3, three ticks → loading_move 1 cycle, executing_move until 1 cycle after 3rd edge; move_done 0→1, moveind=1, stepfinished=0001, underrun pulse.
- buffer_size=3, stepready=111 with durations 1,2,1 → moveind 0,1,2,0; move_done toggles 3 times; buffer_empty=1 at end.
- Duration 0 in slot 0 → move_done_pulse exactly 2 cycles after stepready toggle, no tick needed.
- Duration 5, hold high over ticks 2–3 → only the 3 unheld edges count; completion after 5 unheld edges.
- Four slots pending, abort mid-RUN of slot 1 → stepfinished=stepready, moveind=0, abort_done pulse, buffer_empty=1, move_done unchanged.
- All four slots pending → buffer_dtr=0; after first completion → buffer_dtr=1.
